// File: rtl/sram_port_arbiter_if.sv
// rtl/sram_port_arbiter_if.sv - requester and SRAM bundle for the two-port SRAM arbiter
//
// Port summary (arbiter side = slave):
//   p0_*    instruction-fetch requester: read-only request, grant, response handshake
//   p1_*    data requester: read or byte-strobed write request, grant, response handshake
//   sram_*  pipelined single-port word SRAM: addr/wdata/wren/cs out, rdata in (1-cycle latency)
interface sram_port_arbiter_if #(
  parameter int AW = 16
);
  logic          p0_req;
  logic [AW-1:0] p0_addr;
  logic          p0_gnt;
  logic          p0_rvalid;
  logic [31:0]   p0_rdata;
  logic          p0_rready;

  logic          p1_req;
  logic          p1_write;
  logic [AW-1:0] p1_addr;
  logic [31:0]   p1_wdata;
  logic [3:0]    p1_wstrb;
  logic          p1_gnt;
  logic          p1_rvalid;
  logic [31:0]   p1_rdata;
  logic          p1_rready;

  logic [AW-1:0] sram_addr;
  logic [31:0]   sram_wdata;
  logic [3:0]    sram_wren;
  logic          sram_cs;
  logic [31:0]   sram_rdata;

  modport slave (
    input  p0_req, p0_addr, p0_rready,
    output p0_gnt, p0_rvalid, p0_rdata,
    input  p1_req, p1_write, p1_addr, p1_wdata, p1_wstrb, p1_rready,
    output p1_gnt, p1_rvalid, p1_rdata,
    output sram_addr, sram_wdata, sram_wren, sram_cs,
    input  sram_rdata
  );

  modport master (
    output p0_req, p0_addr, p0_rready,
    input  p0_gnt, p0_rvalid, p0_rdata,
    output p1_req, p1_write, p1_addr, p1_wdata, p1_wstrb, p1_rready,
    input  p1_gnt, p1_rvalid, p1_rdata,
    input  sram_addr, sram_wdata, sram_wren, sram_cs,
    output sram_rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - shares one pipelined word SRAM between a fetch port and a data port
//
// Purpose: grants at most one requester per cycle, drives the SRAM combinationally
// for the granted request, and steers the returned read word into a per-port
// response register with a valid/ready handshake (2-cycle grant-to-valid).
//
// Ports:
//   clk     clock, all state on rising edge
//   resetn  synchronous active-low reset
//   bus     sram_port_arbiter_if.slave: p0_* (read-only fetch), p1_* (read/write data),
//           sram_* (address/control out, read data in)
//
// Parameters:
//   AW      word address width, must match the SRAM
//   RR_EN   1 = round-robin on ties, 0 = port 1 always wins ties
module sram_port_arbiter #(
  parameter int AW    = 16,
  parameter bit RR_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 resetn,
  sram_port_arbiter_if.slave   bus
);

  // Read tracking: inflight_p is set by the grant edge and cleared by the edge
  // that captures the SRAM word. Only one grant happens per cycle, so at most
  // one inflight bit is ever set and it doubles as the owner id of sram_rdata.
  logic        inflight0;
  logic        inflight1;
  logic        last_gnt;      // 0 = port 0 granted last, 1 = port 1

  logic        rvalid0;
  logic        rvalid1;
  logic [31:0] rdata0;
  logic [31:0] rdata1;

  logic        rd0_ok;
  logic        rd1_ok;
  logic        elig0;
  logic        elig1;
  logic        pick1;
  logic        gnt0;
  logic        gnt1;

  logic [AW-1:0] addr_mux;
  logic [31:0]   wdata_mux;
  logic [3:0]    wren_mux;

  // Eligibility and arbitration
  always_comb begin
    // A read may issue only when nothing is in flight for that port and its
    // response register will be free at the edge the new word lands.
    rd0_ok = !inflight0 && (!rvalid0 || bus.p0_rready);
    rd1_ok = !inflight1 && (!rvalid1 || bus.p1_rready);

    elig0  = bus.p0_req && rd0_ok;
    elig1  = bus.p1_req && (bus.p1_write || rd1_ok);

    // Tie-break winner: round-robin gives the port that did not win last.
    pick1  = RR_EN ? (last_gnt == 1'b0) : 1'b1;

    gnt0   = resetn && elig0 && !(elig1 && pick1);
    gnt1   = resetn && elig1 && !(elig0 && !pick1);
  end

  // SRAM drive for the granted request; all zero when idle
  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    wren_mux  = '0;
    if (gnt1) begin
      addr_mux  = bus.p1_addr;
      wdata_mux = bus.p1_wdata;
      wren_mux  = bus.p1_write ? bus.p1_wstrb : 4'b0000;
    end else if (gnt0) begin
      addr_mux  = bus.p0_addr;
    end
  end

  assign bus.sram_addr  = addr_mux;
  assign bus.sram_wdata = wdata_mux;
  assign bus.sram_wren  = wren_mux;
  assign bus.sram_cs    = gnt0 || gnt1;

  assign bus.p0_gnt     = gnt0;
  assign bus.p1_gnt     = gnt1;

  // Read pipeline, response registers and round-robin pointer
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // Clearing inflight here drops any read caught by reset, so its word is
      // never loaded into a response register.
      inflight0 <= 1'b0;
      inflight1 <= 1'b0;
      last_gnt  <= 1'b1;
      rvalid0   <= 1'b0;
      rvalid1   <= 1'b0;
      rdata0    <= '0;
      rdata1    <= '0;
    end else begin
      inflight0 <= gnt0;
      inflight1 <= gnt1 && !bus.p1_write;

      if (gnt0 || gnt1) begin
        last_gnt <= gnt1;
      end

      // A load coinciding with consumption wins, keeping rvalid high.
      if (inflight0) begin
        rdata0  <= bus.sram_rdata;
        rvalid0 <= 1'b1;
      end else if (bus.p0_rready) begin
        rvalid0 <= 1'b0;
      end

      if (inflight1) begin
        rdata1  <= bus.sram_rdata;
        rvalid1 <= 1'b1;
      end else if (bus.p1_rready) begin
        rvalid1 <= 1'b0;
      end
    end
  end

  assign bus.p0_rvalid = rvalid0;
  assign bus.p0_rdata  = rdata0;
  assign bus.p1_rvalid = rvalid1;
  assign bus.p1_rdata  = rdata1;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - directed self-checking bench for sram_port_arbiter
module tb_sram_port_arbiter;

  logic clk;
  logic resetn;

  int n_checks = 0;
  int n_pass   = 0;

  sram_port_arbiter_if #(.AW(16)) bus_rr ();
  sram_port_arbiter_if #(.AW(16)) bus_fp ();

  sram_port_arbiter #(.AW(16), .RR_EN(1'b1)) dut_rr (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_rr)
  );

  sram_port_arbiter #(.AW(16), .RR_EN(1'b0)) dut_fp (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus_fp)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory contents after reset: a recognisable word per address
  function automatic logic [31:0] pat(input int a);
    logic [15:0] lo;
    lo = a[15:0];
    return 32'hC0DE_0000 | {16'h0000, lo};
  endfunction

  // SRAM models: reseeded while reset is low, byte writes, 1-cycle read latency
  logic [31:0] mem_rr [0:255];
  logic [31:0] mem_fp [0:255];
  logic [31:0] rd_rr;
  logic [31:0] rd_fp;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) mem_rr[i] <= pat(i);
    end else if (bus_rr.sram_cs) begin
      for (int b = 0; b < 4; b++)
        if (bus_rr.sram_wren[b]) mem_rr[bus_rr.sram_addr[7:0]][b*8 +: 8] <= bus_rr.sram_wdata[b*8 +: 8];
      rd_rr <= mem_rr[bus_rr.sram_addr[7:0]];
    end
  end

  always @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < 256; i++) mem_fp[i] <= pat(i);
    end else if (bus_fp.sram_cs) begin
      for (int b = 0; b < 4; b++)
        if (bus_fp.sram_wren[b]) mem_fp[bus_fp.sram_addr[7:0]][b*8 +: 8] <= bus_fp.sram_wdata[b*8 +: 8];
      rd_fp <= mem_fp[bus_fp.sram_addr[7:0]];
    end
  end

  assign bus_rr.sram_rdata = rd_rr;
  assign bus_fp.sram_rdata = rd_fp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic rr_p0(input logic req, input logic [15:0] addr);
    bus_rr.p0_req  = req;
    bus_rr.p0_addr = addr;
  endtask

  task automatic rr_p1(input logic req, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    bus_rr.p1_req   = req;
    bus_rr.p1_write = wr;
    bus_rr.p1_addr  = addr;
    bus_rr.p1_wdata = wdata;
    bus_rr.p1_wstrb = wstrb;
  endtask

  task automatic fp_p0(input logic req, input logic [15:0] addr);
    bus_fp.p0_req  = req;
    bus_fp.p0_addr = addr;
  endtask

  task automatic fp_p1(input logic req, input logic wr, input logic [15:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
    bus_fp.p1_req   = req;
    bus_fp.p1_write = wr;
    bus_fp.p1_addr  = addr;
    bus_fp.p1_wdata = wdata;
    bus_fp.p1_wstrb = wstrb;
  endtask

  // Inputs change on the falling edge; outputs are checked 1 time unit later.
  initial begin
    resetn = 1'b0;
    bus_rr.p0_rready = 1'b1;
    bus_rr.p1_rready = 1'b1;
    bus_fp.p0_rready = 1'b1;
    bus_fp.p1_rready = 1'b1;
    fp_p0(1'b0, 16'h0);
    fp_p1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0);

    // 1: reset with both requesting, then first grant and read latency
    rr_p0(1'b1, 16'h0005);
    rr_p1(1'b1, 1'b0, 16'h0006, 32'h0, 4'h0);
    repeat (3) @(negedge clk);
    #1;
    check("rst_p0_gnt", 32'(bus_rr.p0_gnt), 0);
    check("rst_p1_gnt", 32'(bus_rr.p1_gnt), 0);
    check("rst_cs", 32'(bus_rr.sram_cs), 0);
    check("rst_p0_rvalid", 32'(bus_rr.p0_rvalid), 0);
    check("rst_p1_rvalid", 32'(bus_rr.p1_rvalid), 0);
    check("rst_p0_rdata", bus_rr.p0_rdata, 0);
    check("rst_p1_rdata", bus_rr.p1_rdata, 0);

    @(negedge clk); resetn = 1'b1; #1;
    check("t1_first_p0_gnt", 32'(bus_rr.p0_gnt), 1);
    check("t1_first_p1_gnt", 32'(bus_rr.p1_gnt), 0);
    check("t1_cs", 32'(bus_rr.sram_cs), 1);
    check("t1_addr", 32'(bus_rr.sram_addr), 32'h5);
    @(negedge clk); rr_p0(1'b0, 16'h0); #1;
    check("t1_p1_gnt", 32'(bus_rr.p1_gnt), 1);
    check("t1_p1_addr", 32'(bus_rr.sram_addr), 32'h6);
    check("t1_p0_rvalid_early", 32'(bus_rr.p0_rvalid), 0);
    @(negedge clk); rr_p1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
    check("t1_p0_rvalid", 32'(bus_rr.p0_rvalid), 1);
    check("t1_p0_rdata", bus_rr.p0_rdata, pat(5));
    check("t1_p1_rvalid_early", 32'(bus_rr.p1_rvalid), 0);
    @(negedge clk); #1;
    check("t1_p1_rvalid", 32'(bus_rr.p1_rvalid), 1);
    check("t1_p1_rdata", bus_rr.p1_rdata, pat(6));
    check("t1_p0_rvalid_clr", 32'(bus_rr.p0_rvalid), 0);

    // 2: byte-strobed write, zero-strobe write, read-after-write
    @(negedge clk); rr_p1(1'b1, 1'b1, 16'h0010, 32'hDEADBEEF, 4'hF); #1;
    check("t2_w0_gnt", 32'(bus_rr.p1_gnt), 1);
    check("t2_w0_wren", 32'(bus_rr.sram_wren), 32'hF);
    check("t2_w0_wdata", bus_rr.sram_wdata, 32'hDEADBEEF);
    @(negedge clk); rr_p1(1'b1, 1'b1, 16'h0010, 32'h11223344, 4'h3); #1;
    check("t2_w1_gnt", 32'(bus_rr.p1_gnt), 1);
    check("t2_w1_wren", 32'(bus_rr.sram_wren), 32'h3);
    @(negedge clk); rr_p1(1'b1, 1'b1, 16'h0010, 32'hFFFFFFFF, 4'h0); #1;
    check("t2_w0strb_gnt", 32'(bus_rr.p1_gnt), 1);
    check("t2_w0strb_cs", 32'(bus_rr.sram_cs), 1);
    check("t2_w0strb_wren", 32'(bus_rr.sram_wren), 0);
    @(negedge clk); rr_p1(1'b1, 1'b0, 16'h0010, 32'h0, 4'h0); #1;
    check("t2_rd_gnt", 32'(bus_rr.p1_gnt), 1);
    check("t2_rd_wren", 32'(bus_rr.sram_wren), 0);
    @(negedge clk); rr_p1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
    check("t2_rvalid_early", 32'(bus_rr.p1_rvalid), 0);
    @(negedge clk); #1;
    check("t2_rvalid", 32'(bus_rr.p1_rvalid), 1);
    check("t2_rdata", bus_rr.p1_rdata, 32'hDEAD3344);

    // 3: round-robin, both reading continuously, full SRAM utilisation
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rr_p0(i < 8, 16'(32'h20 + (i + 1) / 2));
      rr_p1(i < 8, 1'b0, 16'(32'h40 + i / 2), 32'h0, 4'h0);
      #1;
      check("t3_p0_gnt", 32'(bus_rr.p0_gnt), 32'(i < 8 && i % 2 == 0));
      check("t3_p1_gnt", 32'(bus_rr.p1_gnt), 32'(i < 8 && i % 2 == 1));
      check("t3_cs", 32'(bus_rr.sram_cs), 32'(i < 8));
      check("t3_p0_rvalid", 32'(bus_rr.p0_rvalid), 32'(i >= 2 && i % 2 == 0));
      check("t3_p1_rvalid", 32'(bus_rr.p1_rvalid), 32'(i >= 3 && i % 2 == 1));
      if (i >= 2 && i % 2 == 0) check("t3_p0_rdata", bus_rr.p0_rdata, pat(32'h20 + (i - 2) / 2));
      if (i >= 3 && i % 2 == 1) check("t3_p1_rdata", bus_rr.p1_rdata, pat(32'h40 + (i - 3) / 2));
    end

    // 4: p0 response back-pressure; p1 writes keep flowing
    @(negedge clk); bus_rr.p0_rready = 1'b0; rr_p0(1'b1, 16'h0007); #1;
    check("t4_p0_gnt", 32'(bus_rr.p0_gnt), 1);
    @(negedge clk); rr_p0(1'b1, 16'h0008); rr_p1(1'b1, 1'b1, 16'h0030, 32'hA0A0A0A0, 4'hF); #1;
    check("t4_c1_p0_gnt", 32'(bus_rr.p0_gnt), 0);
    check("t4_c1_p1_gnt", 32'(bus_rr.p1_gnt), 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); rr_p1(1'b1, 1'b1, 16'(32'h31 + k), 32'hB0B0B0B0, 4'hF); #1;
      check("t4_hold_p0_gnt", 32'(bus_rr.p0_gnt), 0);
      check("t4_hold_p1_gnt", 32'(bus_rr.p1_gnt), 1);
      check("t4_hold_rvalid", 32'(bus_rr.p0_rvalid), 1);
      check("t4_hold_rdata", bus_rr.p0_rdata, pat(7));
    end
    @(negedge clk); bus_rr.p0_rready = 1'b1; rr_p1(1'b1, 1'b1, 16'h0033, 32'hC0C0C0C0, 4'hF); #1;
    check("t4_release_p0_gnt", 32'(bus_rr.p0_gnt), 1);
    check("t4_release_p1_gnt", 32'(bus_rr.p1_gnt), 0);
    @(negedge clk); rr_p0(1'b0, 16'h0); #1;
    check("t4_p1_after", 32'(bus_rr.p1_gnt), 1);
    check("t4_rvalid_clr", 32'(bus_rr.p0_rvalid), 0);
    @(negedge clk); rr_p1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
    check("t4_next_rvalid", 32'(bus_rr.p0_rvalid), 1);
    check("t4_next_rdata", bus_rr.p0_rdata, pat(8));

    // 6: reset during an in-flight p1 read discards it
    @(negedge clk); rr_p1(1'b1, 1'b0, 16'h0050, 32'h0, 4'h0); #1;
    check("t6_gnt", 32'(bus_rr.p1_gnt), 1);
    @(negedge clk); rr_p1(1'b1, 1'b0, 16'h0051, 32'h0, 4'h0); resetn = 1'b0; #1;
    check("t6_rst_gnt", 32'(bus_rr.p1_gnt), 0);
    check("t6_rst_cs", 32'(bus_rr.sram_cs), 0);
    @(negedge clk); #1;
    check("t6_rst_rvalid", 32'(bus_rr.p1_rvalid), 0);
    @(negedge clk); resetn = 1'b1; rr_p0(1'b1, 16'h0052); #1;
    check("t6_tie_p0_gnt", 32'(bus_rr.p0_gnt), 1);
    check("t6_tie_p1_gnt", 32'(bus_rr.p1_gnt), 0);
    check("t6_no_stale", 32'(bus_rr.p1_rvalid), 0);
    @(negedge clk); rr_p0(1'b0, 16'h0); #1;
    check("t6_p1_gnt", 32'(bus_rr.p1_gnt), 1);
    check("t6_p1_addr", 32'(bus_rr.sram_addr), 32'h51);
    check("t6_no_stale2", 32'(bus_rr.p1_rvalid), 0);
    @(negedge clk); rr_p1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
    check("t6_p0_rdata", bus_rr.p0_rdata, pat(32'h52));
    check("t6_p1_rvalid_early", 32'(bus_rr.p1_rvalid), 0);
    @(negedge clk); #1;
    check("t6_p1_rvalid", 32'(bus_rr.p1_rvalid), 1);
    check("t6_p1_rdata", bus_rr.p1_rdata, pat(32'h51));

    // 5: fixed priority, p1 writing continuously starves p0
    fp_p0(1'b1, 16'h0060);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); fp_p1(1'b1, 1'b1, 16'(32'h61 + k), 32'h100 + k, 4'hF); #1;
      check("t5_p1_gnt", 32'(bus_fp.p1_gnt), 1);
      check("t5_p0_gnt", 32'(bus_fp.p0_gnt), 0);
    end
    @(negedge clk); fp_p1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
    check("t5_p0_gnt_free", 32'(bus_fp.p0_gnt), 1);
    check("t5_p0_addr", 32'(bus_fp.sram_addr), 32'h60);
    @(negedge clk); fp_p0(1'b0, 16'h0); #1;
    check("t5_rvalid_early", 32'(bus_fp.p0_rvalid), 0);
    @(negedge clk); fp_p0(1'b1, 16'h0062); fp_p1(1'b1, 1'b0, 16'h0061, 32'h0, 4'h0); #1;
    check("t5_rvalid", 32'(bus_fp.p0_rvalid), 1);
    check("t5_rdata", bus_fp.p0_rdata, pat(32'h60));
    check("t5_tie_p1_gnt", 32'(bus_fp.p1_gnt), 1);
    check("t5_tie_p0_gnt", 32'(bus_fp.p0_gnt), 0);
    @(negedge clk); fp_p1(1'b0, 1'b0, 16'h0, 32'h0, 4'h0); #1;
    check("t5_p0_gnt2", 32'(bus_fp.p0_gnt), 1);
    @(negedge clk); fp_p0(1'b0, 16'h0); #1;
    check("t5_p1_rvalid", 32'(bus_fp.p1_rvalid), 1);
    check("t5_p1_rdata", bus_fp.p1_rdata, 32'h100);
    @(negedge clk); #1;
    check("t5_p0_rvalid2", 32'(bus_fp.p0_rvalid), 1);
    check("t5_p0_rdata2", bus_fp.p0_rdata, 32'h101);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
